// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO result registers.
// A mul/div is accepted in IDLE. Its operands are latched at that edge.
// The result is written to HI/LO after a fixed, parameterised latency.
// mthi/mtlo write HI/LO directly and never raise busy.
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // Only the low two op bits are needed once an arithmetic op is in flight
  localparam logic [1:0] MODE_MULT  = 2'b00;
  localparam logic [1:0] MODE_MULTU = 2'b01;
  localparam logic [1:0] MODE_DIV   = 2'b10;
  localparam logic [1:0] MODE_DIVU  = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               busy_q, busy_next;
  logic [WIDTH-1:0]   hi_q, hi_next;
  logic [WIDTH-1:0]   lo_q, lo_next;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [1:0]         mode_q;
  logic               load_ops;

  logic [WIDTH-1:0]   res_hi, res_lo;

  logic [2*WIDTH-1:0]        prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic signed [WIDTH-1:0]   sa;
  logic signed [WIDTH-1:0]   sb_safe;
  logic signed [WIDTH-1:0]   quot_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]          ub_safe;
  logic [WIDTH-1:0]          quot_u;
  logic [WIDTH-1:0]          rem_u;
  logic                      div_zero;
  logic                      div_ovf;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // State, counter, HI/LO and busy registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      busy_q <= busy_next;
      hi_q   <= hi_next;
      lo_q   <= lo_next;
    end
  end

  // Operand capture at accept so later changes on a/b are invisible
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= MODE_MULT;
    end else if (load_ops) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= op[1:0];
    end
  end

  // Next-state logic: accept/mthi/mtlo in IDLE, count down and retire in RUN
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy_next  = busy_q;
    hi_next    = hi_q;
    lo_next    = lo_q;
    load_ops   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              load_ops   = 1'b1;
              cnt_next   = CNT_W'(MUL_CYCLES);
              state_next = RUN;
              busy_next  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              load_ops   = 1'b1;
              cnt_next   = CNT_W'(DIV_CYCLES);
              state_next = RUN;
              busy_next  = 1'b1;
            end
            OP_MTHI: hi_next = a;
            OP_MTLO: lo_next = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt_next == '0) begin
          hi_next    = res_hi;
          lo_next    = lo_from_res(res_lo);
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  function automatic logic [WIDTH-1:0] lo_from_res(input logic [WIDTH-1:0] v);
    return v;
  endfunction

  // Signed and unsigned products over the full double width
  always_comb begin
    prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  end

  // Quotient/remainder; zero and overflow divisors are swapped for 1 so the
  // dividers never see an undefined case, and the result mux overrides them
  always_comb begin
    div_zero = (b_q == '0);
    div_ovf  = (a_q == MOST_NEG) && (b_q == ALL_ONES);
    sa       = a_q;
    sb_safe  = (div_zero || div_ovf) ? ONE : b_q;
    ub_safe  = div_zero ? ONE : b_q;
    quot_s   = sa / sb_safe;
    rem_s    = sa % sb_safe;
    quot_u   = a_q / ub_safe;
    rem_u    = a_q % ub_safe;
  end

  // Result selection by the latched operation, including divide corner cases
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (mode_q)
      MODE_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      MODE_MULTU: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
      end
      MODE_DIV: begin
        if (div_zero) begin
          res_hi = a_q;
          res_lo = ALL_ONES;
        end else if (div_ovf) begin
          res_hi = '0;
          res_lo = a_q;
        end else begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      MODE_DIVU: begin
        if (div_zero) begin
          res_hi = a_q;
          res_lo = ALL_ONES;
        end else begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit with HI/LO result registers for the EX stage of the pipelined MIPS core. It supersedes the fixed 32-bit multiplier with these additions:
- signed and unsigned divide;
- configurable operand width and per-operation latency;
- a `busy` handshake that the hazard unit uses to stall `mfhi`/`mflo` and further mul/div issue;
- direct HI/LO writes for `mthi`/`mtlo`.

## Interface

Parameters
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits.
- `MUL_CYCLES`, 5: cycles from accepted multiply to result; must be ≥ 1.
- `DIV_CYCLES`, 10: cycles from accepted divide to result; must be ≥ 1.

Ports
- `clk` input, 1: rising-edge clock.
- `reset` input, 1: synchronous, active-high.
- `start` input, 1: issue request, qualified by `op`.
- `op` input, 3 bits. Encoding:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU;
  - 100 MTHI, 101 MTLO;
  - 110 and 111 are no-ops.
- `a` input, `WIDTH`: rs operand (dividend / multiplicand / mthi/mtlo data).
- `b` input, `WIDTH`: rt operand (divisor / multiplier).
- `busy` output, 1: operation in flight; registered.
- `hi` output, `WIDTH`: HI register.
- `lo` output, `WIDTH`: LO register.

## Operation

- States: IDLE and RUN, plus a down-counter `cnt` of width clog2(max latency)+1.
- In IDLE, `start`=1 is sampled at a rising edge:
  - op 000–011: latch `a`, `b` and `op`; load `cnt` with MUL_CYCLES or DIV_CYCLES; go to RUN. HI and LO are not modified yet.
  - op 100: `hi` ← `a` at this edge. Stay IDLE; `busy` stays 0.
  - op 101: `lo` ← `a` at this edge. Stay IDLE; `busy` stays 0.
  - op 110/111: no effect.
- In RUN, `cnt` decrements each edge. On the edge where `cnt` reaches 0:
  - write the result to HI/LO;
  - `busy` ← 0;
  - return to IDLE.
- `start` while `busy`=1 is ignored entirely, including mthi/mtlo. The hazard unit must not issue then.
- Operands are latched at accept. Changes on `a`/`b` during RUN have no effect.
- Arithmetic (two's complement, full 2·`WIDTH` product):
  - MULT: {hi,lo} = signed(a) × signed(b).
  - MULTU: {hi,lo} = unsigned(a) × unsigned(b).
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (DIV or DIVU): lo = all ones, hi = a.
  - Signed overflow, DIV with a = most negative and b = −1: lo = a, hi = 0.
- Implementation of the datapath is free: a combinational result registered at the end, or an iterative shift-add / restoring divider. Only the cycle-exact interface behaviour is fixed.

## Timing

- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, state IDLE, `cnt` = 0.
- Reset has priority over everything. Reset during RUN aborts the operation with no HI/LO write, and the unit is in IDLE on the following cycle.
- Latency, for a mul/div accepted at edge t0:
  - `busy` = 1 from just after t0 until edge t0+L, where L = MUL_CYCLES or DIV_CYCLES. It is high for exactly L cycles.
  - `hi`/`lo` take the new value at edge t0+L, the same edge at which `busy` falls.
- Back-to-back issue: a new `start` is accepted at edge t0+L+1, the first edge sampling `busy` = 0. A `start` at edge t0+L itself is ignored.
- mthi/mtlo: written at the accepting edge and visible the next cycle. They never raise `busy`.
- `hi`/`lo` hold their values at all other times. During RUN they keep their pre-issue values.

## Test plan

1. **Signed multiply.** Reset, then MULT with a = 0xFFFFFFFD (−3), b = 5 → `busy` high for 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
2. **Unsigned multiply and back-to-back issue.** MULTU with the same operands → hi = 0x00000004, lo = 0xFFFFFFF1. A second `start` at the result edge is ignored; one cycle later it is accepted.
3. **Signed divide and overflow.** DIV with a = −7, b = 2 → after 10 cycles lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV with a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0.
4. **Divide by zero.** DIVU with a = 7, b = 0 → lo = 0xFFFFFFFF, hi = 0x00000007.
5. **mthi/mtlo and blocking.**
   - MTHI with a = 0x12345678, then MTLO with a = 0x9ABCDEF0 on consecutive cycles → both visible the next cycle; `busy` never asserts.
   - MTLO issued while busy → lo unchanged.
6. **Reset mid-operation.** Start a MULT, assert `reset` on the 3rd busy cycle → next cycle hi = lo = 0 and `busy` = 0; no later result write occurs. Repeat with `WIDTH` = 16, MUL_CYCLES = 1: −3 × 5 → hi = 0xFFFF, lo = 0xFFF1 one cycle after issue.
